// File: rtl/elevator_motion_ctrl.sv
// Collective-selective car motion controller for a 7-floor, 2-way elevator.
// Sequences IDLE / OPEN / MOVING using door-dwell and per-floor travel timers.
module elevator_motion_ctrl #(
    parameter int DOOR_TICKS   = 8,
    parameter int TRAVEL_TICKS = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [13:0] floorButton,
    input  logic [9:1]  internalButton,
    output logic [2:0]  currentFloor,
    output logic [1:0]  currentDirection,
    output logic        doorState,
    output logic        move
);
    localparam logic [1:0] STOP = 2'b00;
    localparam logic [1:0] UP   = 2'b10;
    localparam logic [1:0] DOWN = 2'b01;
    localparam int DW = $clog2(DOOR_TICKS + 1);
    localparam int TW = $clog2(TRAVEL_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        MOVING
    } state_t;

    state_t        state, state_n;
    logic [2:0]    floor_q, floor_n;
    logic [1:0]    dir_q, dir_n;
    logic [DW-1:0] dtmr, dtmr_n;
    logic [TW-1:0] ttmr, ttmr_n;

    // Per-floor vectors indexed by floor number; bit 0 is unused.
    logic [7:0] up_call, dn_call, car, req;
    logic       here, above, below;
    logic [2:0] nfloor;
    logic       ahead_n, fwd_call, rev_call;

    assign up_call = {floorButton[13], floorButton[11], floorButton[9],
                      floorButton[7], floorButton[5], floorButton[3],
                      floorButton[1], 1'b0};
    assign dn_call = {floorButton[12], floorButton[10], floorButton[8],
                      floorButton[6], floorButton[4], floorButton[2],
                      floorButton[0], 1'b0};
    assign car     = {internalButton[7:1], 1'b0};
    assign req     = car | up_call | dn_call;

    function automatic logic reqs_above(input logic [7:0] r,
                                        input logic [2:0] f);
        logic [7:0] mask;
        mask = ~((8'd2 << f) - 8'd1);
        return |(r & mask);
    endfunction

    function automatic logic reqs_below(input logic [7:0] r,
                                        input logic [2:0] f);
        logic [7:0] mask;
        mask = ((8'd1 << f) - 8'd1) & 8'hFE;
        return |(r & mask);
    endfunction

    always_comb begin
        here  = req[floor_q];
        above = reqs_above(req, floor_q);
        below = reqs_below(req, floor_q);

        nfloor = floor_q;
        if (dir_q == UP && floor_q != 3'd7)
            nfloor = floor_q + 3'd1;
        else if (dir_q == DOWN && floor_q != 3'd1)
            nfloor = floor_q - 3'd1;

        ahead_n  = 1'b0;
        fwd_call = 1'b0;
        rev_call = 1'b0;
        if (dir_q == UP) begin
            ahead_n  = reqs_above(req, nfloor);
            fwd_call = up_call[nfloor];
            rev_call = dn_call[nfloor];
        end else if (dir_q == DOWN) begin
            ahead_n  = reqs_below(req, nfloor);
            fwd_call = dn_call[nfloor];
            rev_call = up_call[nfloor];
        end
    end

    always_comb begin
        state_n = state;
        floor_n = floor_q;
        dir_n   = dir_q;
        dtmr_n  = dtmr;
        ttmr_n  = ttmr;
        unique case (state)
            IDLE: begin
                if (here || internalButton[9]) begin
                    state_n = OPEN;
                    dtmr_n  = DW'(DOOR_TICKS);
                    if (up_call[floor_q])
                        dir_n = UP;
                    else if (dn_call[floor_q])
                        dir_n = DOWN;
                end else if (dir_q != DOWN && above) begin
                    state_n = MOVING;
                    dir_n   = UP;
                    ttmr_n  = TW'(TRAVEL_TICKS);
                end else if (below) begin
                    state_n = MOVING;
                    dir_n   = DOWN;
                    ttmr_n  = TW'(TRAVEL_TICKS);
                end else if (above) begin
                    state_n = MOVING;
                    dir_n   = UP;
                    ttmr_n  = TW'(TRAVEL_TICKS);
                end else begin
                    dir_n = STOP;
                end
            end
            OPEN: begin
                if (internalButton[9])
                    dtmr_n = DW'(DOOR_TICKS);
                else if (internalButton[8] && dtmr > DW'(1))
                    dtmr_n = DW'(1);
                else
                    dtmr_n = dtmr - DW'(1);
                if (dtmr_n == '0)
                    state_n = IDLE;
            end
            MOVING: begin
                if (ttmr > TW'(1)) begin
                    ttmr_n = ttmr - TW'(1);
                end else begin
                    floor_n = nfloor;
                    // Decide on arrival using the floor being entered.
                    if (car[nfloor] || fwd_call || !ahead_n) begin
                        ttmr_n = '0;
                        if (req[nfloor]) begin
                            state_n = OPEN;
                            dtmr_n  = DW'(DOOR_TICKS);
                            if (!ahead_n && !fwd_call && rev_call)
                                dir_n = ~dir_q;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        ttmr_n = TW'(TRAVEL_TICKS);
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            floor_q <= 3'd1;
            dir_q   <= STOP;
            dtmr    <= '0;
            ttmr    <= '0;
        end else if (enable) begin
            state   <= state_n;
            floor_q <= floor_n;
            dir_q   <= dir_n;
            dtmr    <= dtmr_n;
            ttmr    <= ttmr_n;
        end
    end

    assign currentFloor     = floor_q;
    assign currentDirection = dir_q;
    assign doorState        = (state == OPEN);
    assign move             = (state == MOVING);

endmodule

// File: tb/tb_elevator_motion_ctrl.sv
// Scoreboard bench for elevator_motion_ctrl: stimulus queues cycle-stamped
// expected outputs, a negedge monitor pops and compares them.
module tb_elevator_motion_ctrl;
  localparam logic [1:0] ST = 2'b00;
  localparam logic [1:0] UP = 2'b10;
  localparam logic [1:0] DN = 2'b01;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [13:0] fb;
  logic [9:1]  ib;
  logic [2:0]  currentFloor;
  logic [1:0]  currentDirection;
  logic        doorState;
  logic        move;

  elevator_motion_ctrl #(.DOOR_TICKS(8), .TRAVEL_TICKS(16)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .floorButton(fb),
    .internalButton(ib),
    .currentFloor(currentFloor),
    .currentDirection(currentDirection),
    .doorState(doorState),
    .move(move)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    int         at;
    logic [2:0] fl;
    logic [1:0] dr;
    logic       dn;
    logic       mv;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  always @(negedge clk) begin
    while (exp_q.size() != 0 && exp_q[0].at <= cyc) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      if (e.at != cyc || currentFloor !== e.fl ||
          currentDirection !== e.dr || doorState !== e.dn ||
          move !== e.mv) begin
        errors++;
        $display("FAIL %s cyc=%0d(want %0d): got fl=%0d dir=%b door=%b move=%b, want fl=%0d dir=%b door=%b move=%b",
                 nm, cyc, e.at, currentFloor, currentDirection,
                 doorState, move, e.fl, e.dr, e.dn, e.mv);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_at(input int n, input logic [2:0] fl,
                           input logic [1:0] dr, input logic dn,
                           input logic mv, input string nm);
    exp_t e;
    e.at = cyc + n;
    e.fl = fl;
    e.dr = dr;
    e.dn = dn;
    e.mv = mv;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic do_reset(input string nm);
    reset = 1'b1;
    expect_at(1, 3'd1, ST, 1'b0, 1'b0, nm);
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    reset  = 1'b1;
    enable = 1'b1;
    fb     = '0;
    ib     = '0;
    @(negedge clk);
    expect_at(1, 3'd1, ST, 1'b0, 1'b0, "init_reset");
    tick(1);
    reset = 1'b0;
    expect_at(1, 3'd1, ST, 1'b0, 1'b0, "init_idle");
    tick(1);

    ib[6] = 1'b1;
    expect_at(1, 3'd1, UP, 1'b0, 1'b1, "p1_depart");
    expect_at(49, 3'd4, UP, 1'b0, 1'b1, "p1_floor4");
    tick(52);
    reset  = 1'b1;
    enable = 1'b0;
    ib     = '0;
    expect_at(1, 3'd1, ST, 1'b0, 1'b0, "p1_reset_mid_move");
    tick(1);
    reset  = 1'b0;
    enable = 1'b1;
    expect_at(2, 3'd1, ST, 1'b0, 1'b0, "p1_idle_after");
    tick(2);

    ib[3] = 1'b1;
    expect_at(1, 3'd1, UP, 1'b0, 1'b1, "p2_depart");
    expect_at(16, 3'd1, UP, 1'b0, 1'b1, "p2_pre_f2");
    expect_at(17, 3'd2, UP, 1'b0, 1'b1, "p2_f2");
    expect_at(32, 3'd2, UP, 1'b0, 1'b1, "p2_pre_f3");
    expect_at(33, 3'd3, UP, 1'b1, 1'b0, "p2_arrive_f3");
    expect_at(40, 3'd3, UP, 1'b1, 1'b0, "p2_door_last");
    expect_at(41, 3'd3, UP, 1'b0, 1'b0, "p2_door_close");
    expect_at(42, 3'd3, ST, 1'b0, 1'b0, "p2_dir_stop");
    tick(33);
    ib[3] = 1'b0;
    tick(9);

    do_reset("p3_reset");
    fb[8] = 1'b1;
    ib[7] = 1'b1;
    expect_at(1, 3'd1, UP, 1'b0, 1'b1, "p3_depart");
    expect_at(65, 3'd5, UP, 1'b0, 1'b1, "p3_pass_f5");
    expect_at(81, 3'd6, UP, 1'b0, 1'b1, "p3_f6");
    expect_at(97, 3'd7, UP, 1'b1, 1'b0, "p3_arrive_f7");
    expect_at(105, 3'd7, UP, 1'b0, 1'b0, "p3_close_f7");
    expect_at(106, 3'd7, DN, 1'b0, 1'b1, "p3_reverse");
    expect_at(137, 3'd6, DN, 1'b0, 1'b1, "p3_down_f6");
    expect_at(138, 3'd5, DN, 1'b1, 1'b0, "p3_arrive_f5");
    expect_at(146, 3'd5, DN, 1'b0, 1'b0, "p3_close_f5");
    expect_at(147, 3'd5, ST, 1'b0, 1'b0, "p3_dir_stop");
    tick(97);
    ib[7] = 1'b0;
    tick(41);
    fb[8] = 1'b0;
    tick(9);

    do_reset("p4_reset");
    ib[2] = 1'b1;
    expect_at(1, 3'd1, UP, 1'b0, 1'b1, "p4_depart");
    expect_at(17, 3'd2, UP, 1'b1, 1'b0, "p4_arrive_f2");
    expect_at(25, 3'd2, UP, 1'b1, 1'b0, "p4_open_extended");
    expect_at(30, 3'd2, UP, 1'b1, 1'b0, "p4_open_last");
    expect_at(31, 3'd2, UP, 1'b0, 1'b0, "p4_close");
    expect_at(32, 3'd2, ST, 1'b0, 1'b0, "p4_dir_stop");
    expect_at(33, 3'd2, ST, 1'b1, 1'b0, "p4_reopen");
    expect_at(36, 3'd2, ST, 1'b1, 1'b0, "p4_close_req");
    expect_at(37, 3'd2, ST, 1'b0, 1'b0, "p4_closed_fast");
    expect_at(39, 3'd2, ST, 1'b1, 1'b0, "p4_reopen2");
    expect_at(41, 3'd2, ST, 1'b1, 1'b0, "p4_both_reload");
    expect_at(47, 3'd2, ST, 1'b1, 1'b0, "p4_both_last");
    expect_at(48, 3'd2, ST, 1'b0, 1'b0, "p4_both_close");
    tick(17);
    ib[2] = 1'b0;
    tick(5);
    ib[9] = 1'b1;
    tick(1);
    ib[9] = 1'b0;
    tick(9);
    ib[9] = 1'b1;
    tick(1);
    ib[9] = 1'b0;
    tick(2);
    ib[8] = 1'b1;
    tick(2);
    ib[8] = 1'b0;
    tick(1);
    ib[9] = 1'b1;
    tick(1);
    ib[8] = 1'b1;
    tick(1);
    ib[9] = 1'b0;
    ib[8] = 1'b0;
    tick(8);

    ib[4] = 1'b1;
    expect_at(1, 3'd2, UP, 1'b0, 1'b1, "p5_depart");
    expect_at(10, 3'd2, UP, 1'b0, 1'b1, "p5_frozen");
    expect_at(25, 3'd2, UP, 1'b0, 1'b1, "p5_frozen_end");
    expect_at(36, 3'd2, UP, 1'b0, 1'b1, "p5_pre_f3");
    expect_at(37, 3'd3, UP, 1'b0, 1'b1, "p5_f3");
    expect_at(53, 3'd4, UP, 1'b1, 1'b0, "p5_arrive_f4");
    expect_at(61, 3'd4, UP, 1'b0, 1'b0, "p5_close");
    expect_at(62, 3'd4, ST, 1'b0, 1'b0, "p5_dir_stop");
    tick(5);
    enable = 1'b0;
    tick(20);
    enable = 1'b1;
    tick(28);
    ib[4] = 1'b0;
    tick(9);

    ib[7] = 1'b1;
    expect_at(1, 3'd4, UP, 1'b0, 1'b1, "p6_depart");
    expect_at(49, 3'd7, UP, 1'b1, 1'b0, "p6_arrive_f7");
    expect_at(57, 3'd7, UP, 1'b0, 1'b0, "p6_close_f7");
    expect_at(58, 3'd7, DN, 1'b0, 1'b1, "p6_go_down");
    expect_at(74, 3'd6, DN, 1'b0, 1'b1, "p6_f6");
    expect_at(153, 3'd2, DN, 1'b0, 1'b1, "p6_pre_f1");
    expect_at(154, 3'd1, UP, 1'b1, 1'b0, "p6_arrive_f1");
    expect_at(162, 3'd1, UP, 1'b0, 1'b0, "p6_close_f1");
    expect_at(163, 3'd1, ST, 1'b0, 1'b0, "p6_dir_stop");
    tick(49);
    ib[7] = 1'b0;
    fb[1] = 1'b1;
    tick(105);
    fb[1] = 1'b0;
    tick(9);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++)
      tick(1);

    checks++;
    if (currentFloor !== 3'd1) begin
      errors++;
      $display("FAIL final_floor got %0d", currentFloor);
    end
    checks++;
    if (currentDirection !== ST) begin
      errors++;
      $display("FAIL final_dir got %b", currentDirection);
    end
    checks++;
    if (doorState !== 1'b0) begin
      errors++;
      $display("FAIL final_door got %b", doorState);
    end
    checks++;
    if (move !== 1'b0) begin
      errors++;
      $display("FAIL final_move got %b", move);
    end

    while (exp_q.size() != 0) begin
      exp_t  e;
      string nm;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      checks++;
      errors++;
      $display("FAIL %s never compared: due cyc=%0d, now cyc=%0d",
               nm, e.at, cyc);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
